// File: rtl/sram_load_pkg.sv
// sram_load_pkg: shared types and helpers for the SRAM load sequencer
//   CFG_W        width of each layer config field
//   state_e      sequencer states
//   cfg_t        registered layer geometry
//   ceil_div_bus ceil(v / 2^lg) using a shift and an OR-reduce of the dropped bits
//   sat          clamp a double-width value to CFG_W bits
package sram_load_pkg;
  localparam int CFG_W = 8;
  localparam int PW = 2 * CFG_W;
  typedef enum logic [2:0] {IDLE, CALC, FIL, IFM, NEXT_Z, DONE} state_e;
  typedef struct packed {
    logic [CFG_W-1:0] div_channel_num;
    logic [CFG_W-1:0] ifm_x;
    logic [CFG_W-1:0] ifm_y;
    logic [CFG_W-1:0] fil_x;
    logic [CFG_W-1:0] fil_y;
  } cfg_t;
  function automatic logic [PW-1:0] ceil_div_bus(input logic [PW-1:0] v, input int unsigned lg);
    logic [PW-1:0] mask;
    mask = PW'((1 << lg) - 1);
    return (v >> lg) + PW'(|(v & mask));
  endfunction
  function automatic logic [CFG_W-1:0] sat(input logic [PW-1:0] v);
    return (|v[PW-1:CFG_W]) ? '1 : v[CFG_W-1:0];
  endfunction
endpackage

// File: rtl/sram_load_sched_wr_port.sv
// sram_wr_port_reg: registered SRAM write-port driver, one cycle behind the accepted beat
//   accept/sparsemap/data/dat_count/chunk_count  beat and address captured on accept
//   wr_*                                         registered write port; wr_valid high only the cycle after accept
module sram_wr_port_reg
  import sram_load_pkg::*;
#(
  parameter int SM_W = 32,
  parameter int D_W  = 256,
  parameter int DC_W = 4,
  parameter int CC_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            accept,
  input  logic [SM_W-1:0] sparsemap,
  input  logic [D_W-1:0]  data,
  input  logic [DC_W-1:0] dat_count,
  input  logic [CC_W-1:0] chunk_count,
  output logic            wr_valid,
  output logic [SM_W-1:0] wr_sparsemap,
  output logic [D_W-1:0]  wr_data,
  output logic [DC_W-1:0] wr_dat_count,
  output logic [CC_W-1:0] wr_chunk_count
);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_valid       <= 1'b0;
      wr_sparsemap   <= '0;
      wr_data        <= '0;
      wr_dat_count   <= '0;
      wr_chunk_count <= '0;
    end else begin
      wr_valid <= accept;
      if (accept) begin
        wr_sparsemap   <= sparsemap;
        wr_data        <= data;
        wr_dat_count   <= dat_count;
        wr_chunk_count <= chunk_count;
      end
    end
  end
endmodule

// File: rtl/sram_load_sched.sv
// sram_load_sched: sequences one layer's filter and IFM chunks from a shared beat stream into the two SRAM write ports
//   clk_i, rst_i (async, active-low)
//   start_i, cfg_*_i          layer start pulse and geometry, sampled in IDLE
//   in_valid_i/in_ready_o     shared sparsemap + nonzero-data beat stream
//   fil_sram_wr_*, ifm_sram_wr_*  registered write ports with dat_count/chunk_count addressing
//   busy_o, finish_o, ovf_o   status; ovf_o sticky until next start
//   SRAM_LOAD_PERF_CNT_EN     adds stall_cnt_o and beat_cnt_o
module sram_load_sched
  import sram_load_pkg::*;
#(
  parameter int BUS_SIZE         = 32,
  parameter int DAT_SIZE         = 8,
  parameter int WR_DAT_CYC_NUM   = 16,
  parameter int SRAM_IFM_NUM     = 64,
  parameter int SRAM_FILTER_NUM  = 64,
  parameter int COMPUTE_UNIT_NUM = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  start_i,
  input  logic [CFG_W-1:0]                      cfg_channel_num_i,
  input  logic [CFG_W-1:0]                      cfg_div_channel_num_i,
  input  logic [CFG_W-1:0]                      cfg_ifm_x_i,
  input  logic [CFG_W-1:0]                      cfg_ifm_y_i,
  input  logic [CFG_W-1:0]                      cfg_fil_x_i,
  input  logic [CFG_W-1:0]                      cfg_fil_y_i,
  input  logic                                  in_valid_i,
  output logic                                  in_ready_o,
  input  logic [BUS_SIZE-1:0]                   in_sparsemap_i,
  input  logic [BUS_SIZE*DAT_SIZE-1:0]          in_nonzero_data_i,
  output logic                                  ifm_sram_wr_valid_o,
  output logic [BUS_SIZE-1:0]                   ifm_sram_wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0]          ifm_sram_wr_nonzero_data_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]     ifm_sram_wr_dat_count_o,
  output logic [$clog2(SRAM_IFM_NUM)-1:0]       ifm_sram_wr_chunk_count_o,
  output logic                                  fil_sram_wr_valid_o,
  output logic [BUS_SIZE-1:0]                   fil_sram_wr_sparsemap_o,
  output logic [BUS_SIZE*DAT_SIZE-1:0]          fil_sram_wr_nonzero_data_o,
  output logic [$clog2(WR_DAT_CYC_NUM)-1:0]     fil_sram_wr_dat_count_o,
  output logic [$clog2(SRAM_FILTER_NUM)-1:0]    fil_sram_wr_chunk_count_o,
  output logic                                  busy_o,
  output logic                                  finish_o,
  output logic                                  ovf_o
`ifdef SRAM_LOAD_PERF_CNT_EN
  ,
  output logic [31:0]                           stall_cnt_o,
  output logic [31:0]                           beat_cnt_o
`endif
);
  localparam int DC_W = $clog2(WR_DAT_CYC_NUM);
  localparam int IC_W = $clog2(SRAM_IFM_NUM);
  localparam int FC_W = $clog2(SRAM_FILTER_NUM);
  localparam int CU_W = (COMPUTE_UNIT_NUM > 1) ? $clog2(COMPUTE_UNIT_NUM) : 1;
  localparam int unsigned BUS_LG = $clog2(BUS_SIZE);
  state_e state_q, state_d;
  cfg_t cfg_q, cfg_in;
  logic [CFG_W-1:0] rem_ch_q, cur_ch_q, fil_beats_q, ifm_beats_q, beat_q, y_idx_q;
  logic [CFG_W-1:0] cur_ch_c, fil_beats_c, ifm_beats_c;
  logic [PW-1:0] fil_prod, fil_tot, ifm_prod;
  logic [CU_W-1:0] cu_idx_q;
  logic [FC_W-1:0] fil_chunk_q;
  logic [IC_W-1:0] ifm_chunk_q;
  logic ovf_q, finish_q, accept, last_beat, cfg_zero;
  assign cfg_in = '{div_channel_num: cfg_div_channel_num_i, ifm_x: cfg_ifm_x_i, ifm_y: cfg_ifm_y_i,
                    fil_x: cfg_fil_x_i, fil_y: cfg_fil_y_i};
  assign cfg_zero = (cfg_channel_num_i == '0) || (cfg_div_channel_num_i == '0) || (cfg_ifm_x_i == '0) ||
                    (cfg_ifm_y_i == '0) || (cfg_fil_x_i == '0) || (cfg_fil_y_i == '0);
  assign in_ready_o = (state_q == FIL) || (state_q == IFM);
  assign busy_o     = state_q != IDLE;
  assign finish_o   = finish_q;
  assign ovf_o      = ovf_q;
  assign accept     = in_valid_i && in_ready_o;
  assign last_beat  = beat_q == (((state_q == FIL) ? fil_beats_q : ifm_beats_q) - CFG_W'(1));
  // The ceil is clamped before the fil_y multiply; since fil_y >= 1 the result equals saturating the full product.
  assign cur_ch_c    = (rem_ch_q <= cfg_q.div_channel_num) ? rem_ch_q : cfg_q.div_channel_num;
  assign fil_prod    = PW'(cfg_q.fil_x) * PW'(cfg_q.div_channel_num);
  assign fil_tot     = PW'(cfg_q.fil_y) * PW'(sat(ceil_div_bus(fil_prod, BUS_LG)));
  assign fil_beats_c = sat(fil_tot);
  assign ifm_prod    = PW'(cfg_q.ifm_x) * PW'(cur_ch_c);
  assign ifm_beats_c = sat(ceil_div_bus(ifm_prod, BUS_LG));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = cfg_zero ? DONE : CALC;
      CALC:    state_d = FIL;
      FIL:     if (accept && last_beat && cu_idx_q == CU_W'(COMPUTE_UNIT_NUM - 1)) state_d = IFM;
      IFM:     if (accept && last_beat && y_idx_q == cfg_q.ifm_y - CFG_W'(1)) state_d = NEXT_Z;
      NEXT_Z:  state_d = (rem_ch_q == cur_ch_q) ? DONE : CALC;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cfg_q       <= '0;
      rem_ch_q    <= '0;
      cur_ch_q    <= '0;
      fil_beats_q <= '0;
      ifm_beats_q <= '0;
      beat_q      <= '0;
      y_idx_q     <= '0;
      cu_idx_q    <= '0;
      fil_chunk_q <= '0;
      ifm_chunk_q <= '0;
      ovf_q       <= 1'b0;
      finish_q    <= 1'b0;
    end else begin
      finish_q <= state_q == DONE;
      if (state_q == IDLE && start_i) begin
        cfg_q       <= cfg_in;
        rem_ch_q    <= cfg_channel_num_i;
        fil_chunk_q <= '0;
        ifm_chunk_q <= '0;
        ovf_q       <= 1'b0;
      end
      if (state_q == CALC) begin
        cur_ch_q    <= cur_ch_c;
        fil_beats_q <= fil_beats_c;
        ifm_beats_q <= ifm_beats_c;
        cu_idx_q    <= '0;
        y_idx_q     <= '0;
        beat_q      <= '0;
        if (32'(fil_beats_c) > WR_DAT_CYC_NUM || 32'(ifm_beats_c) > WR_DAT_CYC_NUM) ovf_q <= 1'b1;
      end
      if (accept) begin
        beat_q <= last_beat ? '0 : beat_q + CFG_W'(1);
        if (last_beat && state_q == FIL) begin
          fil_chunk_q <= fil_chunk_q + FC_W'(1);
          cu_idx_q    <= cu_idx_q + CU_W'(1);
          if (&fil_chunk_q) ovf_q <= 1'b1;
        end
        if (last_beat && state_q == IFM) begin
          ifm_chunk_q <= ifm_chunk_q + IC_W'(1);
          y_idx_q     <= y_idx_q + CFG_W'(1);
          if (&ifm_chunk_q) ovf_q <= 1'b1;
        end
      end
      if (state_q == NEXT_Z) rem_ch_q <= rem_ch_q - cur_ch_q;
    end
  end
  sram_wr_port_reg #(.SM_W(BUS_SIZE), .D_W(BUS_SIZE * DAT_SIZE), .DC_W(DC_W), .CC_W(FC_W)) u_fil (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .accept         (accept && state_q == FIL),
    .sparsemap      (in_sparsemap_i),
    .data           (in_nonzero_data_i),
    .dat_count      (beat_q[DC_W-1:0]),
    .chunk_count    (fil_chunk_q),
    .wr_valid       (fil_sram_wr_valid_o),
    .wr_sparsemap   (fil_sram_wr_sparsemap_o),
    .wr_data        (fil_sram_wr_nonzero_data_o),
    .wr_dat_count   (fil_sram_wr_dat_count_o),
    .wr_chunk_count (fil_sram_wr_chunk_count_o)
  );
  sram_wr_port_reg #(.SM_W(BUS_SIZE), .D_W(BUS_SIZE * DAT_SIZE), .DC_W(DC_W), .CC_W(IC_W)) u_ifm (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .accept         (accept && state_q == IFM),
    .sparsemap      (in_sparsemap_i),
    .data           (in_nonzero_data_i),
    .dat_count      (beat_q[DC_W-1:0]),
    .chunk_count    (ifm_chunk_q),
    .wr_valid       (ifm_sram_wr_valid_o),
    .wr_sparsemap   (ifm_sram_wr_sparsemap_o),
    .wr_data        (ifm_sram_wr_nonzero_data_o),
    .wr_dat_count   (ifm_sram_wr_dat_count_o),
    .wr_chunk_count (ifm_sram_wr_chunk_count_o)
  );
`ifdef SRAM_LOAD_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
      beat_cnt_o  <= '0;
    end else if (state_q == IDLE && start_i) begin
      stall_cnt_o <= '0;
      beat_cnt_o  <= '0;
    end else begin
      if (in_ready_o && !in_valid_i) stall_cnt_o <= stall_cnt_o + 32'd1;
      if (accept) beat_cnt_o <= beat_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_sram_load_sched.sv
// tb_sram_load_sched: randomized scoreboard bench for sram_load_sched
module tb_sram_load_sched;
  localparam int BUS = 32, DAT = 8, WRN = 16, IFMN = 64, FILN = 4, CUN = 2;
  typedef struct packed {
    logic [31:0]  sm;
    logic [255:0] d;
    logic [3:0]   dc;
    logic [5:0]   cc;
  } wr_t;
  typedef struct {
    bit ifm;
    int dc;
    int cc;
  } plan_t;
  logic clk = 0, rst_i = 0, start = 0, in_valid = 0, in_ready;
  logic [7:0] cfg_ch = 0, cfg_div = 0, cfg_ix = 0, cfg_iy = 0, cfg_fx = 0, cfg_fy = 0;
  logic [31:0] in_sm = 0, fil_sm, ifm_sm;
  logic [255:0] in_d = 0, fil_d, ifm_d;
  logic [3:0] fil_dc, ifm_dc;
  logic [1:0] fil_cc;
  logic [5:0] ifm_cc;
  logic fil_v, ifm_v, busy, finish, ovf;
  wr_t fil_q[$], ifm_q[$];
  int checks = 0, passed = 0, cyc = 0, acc_cnt = 0, fin_cnt = 0, fin_cyc = 0;
  logic acc_s = 0, fin_ovf = 0;

  sram_load_sched #(.BUS_SIZE(BUS), .DAT_SIZE(DAT), .WR_DAT_CYC_NUM(WRN), .SRAM_IFM_NUM(IFMN),
                    .SRAM_FILTER_NUM(FILN), .COMPUTE_UNIT_NUM(CUN)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start),
    .cfg_channel_num_i(cfg_ch), .cfg_div_channel_num_i(cfg_div),
    .cfg_ifm_x_i(cfg_ix), .cfg_ifm_y_i(cfg_iy), .cfg_fil_x_i(cfg_fx), .cfg_fil_y_i(cfg_fy),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_sparsemap_i(in_sm), .in_nonzero_data_i(in_d),
    .ifm_sram_wr_valid_o(ifm_v), .ifm_sram_wr_sparsemap_o(ifm_sm), .ifm_sram_wr_nonzero_data_o(ifm_d),
    .ifm_sram_wr_dat_count_o(ifm_dc), .ifm_sram_wr_chunk_count_o(ifm_cc),
    .fil_sram_wr_valid_o(fil_v), .fil_sram_wr_sparsemap_o(fil_sm), .fil_sram_wr_nonzero_data_o(fil_d),
    .fil_sram_wr_dat_count_o(fil_dc), .fil_sram_wr_chunk_count_o(fil_cc),
    .busy_o(busy), .finish_o(finish), .ovf_o(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic void chk(string n, logic [299:0] act, logic [299:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endfunction

  always @(negedge clk) begin
    if (!rst_i) acc_s = 0;
    else begin
      chk("wr_valid_timing", {fil_v & ifm_v, fil_v | ifm_v}, {1'b0, acc_s});
      if (fil_v) begin
        if (fil_q.size() == 0) begin checks++; $display("FAIL fil_unexpected: write with empty scoreboard"); end
        else chk("fil_write", {fil_sm, fil_d, fil_dc, 4'b0, fil_cc}, fil_q.pop_front());
      end
      if (ifm_v) begin
        if (ifm_q.size() == 0) begin checks++; $display("FAIL ifm_unexpected: write with empty scoreboard"); end
        else chk("ifm_write", {ifm_sm, ifm_d, ifm_dc, ifm_cc}, ifm_q.pop_front());
      end
      if (finish) begin fin_cnt++; fin_cyc = cyc; fin_ovf = ovf; end
      acc_s = in_valid & in_ready;
      if (acc_s) acc_cnt++;
    end
  end

  task automatic run_layer(input int ch, div, ix, iy, fx, fy, bub, input bit poke, input int abort_at);
    plan_t plan[$];
    wr_t e;
    int rem, cur, fb, ib, fc, ic, f0, a0, sc, w;
    bit eovf;
    logic rdy;
    rem = ch; fc = 0; ic = 0; eovf = 0;
    if (ch > 0 && div > 0 && ix > 0 && iy > 0 && fx > 0 && fy > 0)
      while (rem > 0) begin
        cur = (rem < div) ? rem : div;
        fb = fy * ((fx * div + BUS - 1) / BUS); if (fb > 255) fb = 255;
        ib = (ix * cur + BUS - 1) / BUS; if (ib > 255) ib = 255;
        if (fb > WRN || ib > WRN) eovf = 1;
        repeat (CUN) begin for (int b = 0; b < fb; b++) plan.push_back('{0, b % WRN, fc % FILN}); fc++; end
        repeat (iy) begin for (int b = 0; b < ib; b++) plan.push_back('{1, b % WRN, ic % IFMN}); ic++; end
        rem -= cur;
      end
    if (fc >= FILN || ic >= IFMN) eovf = 1;
    f0 = fin_cnt; a0 = acc_cnt;
    cfg_ch = 8'(ch); cfg_div = 8'(div); cfg_ix = 8'(ix); cfg_iy = 8'(iy); cfg_fx = 8'(fx); cfg_fy = 8'(fy);
    start = 1; in_valid = (plan.size() == 0);
    @(posedge clk); #1 start = 0; sc = cyc;
    @(negedge clk);
    chk("ovf_clear_on_start", ovf, 0);
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < plan.size(); i++) begin
      if (i == abort_at) begin
        in_valid = 0;
        #2 rst_i = 0;
        #1 chk("rst_mid_outputs", {in_ready, fil_v, ifm_v, busy, finish, ovf, fil_cc, ifm_cc, fil_dc, ifm_dc}, 0);
        repeat (2) @(posedge clk);
        #1 rst_i = 1;
        fil_q.delete(); ifm_q.delete();
        repeat (6) @(posedge clk);
        #1 chk("no_finish_after_reset", fin_cnt - f0, 0);
        chk("idle_after_reset", {busy, in_ready}, 0);
        return;
      end
      while ($urandom_range(99) < bub) begin in_valid = 0; @(posedge clk); #1; end
      e.sm = $urandom;
      for (int k = 0; k < 8; k++) e.d[k*32 +: 32] = $urandom;
      e.dc = 4'(plan[i].dc); e.cc = 6'(plan[i].cc);
      if (plan[i].ifm) ifm_q.push_back(e); else fil_q.push_back(e);
      in_sm = e.sm; in_d = e.d; in_valid = 1;
      if (poke && i == plan.size() / 2) begin start = 1; cfg_ch = 1; cfg_iy = 0; end
      w = 0;
      do begin @(negedge clk); rdy = in_ready; @(posedge clk); #1 start = 0; w++; end while (!rdy && w < 100);
      if (!rdy) begin checks++; $display("FAIL accept_timeout: beat %0d not accepted", i); break; end
    end
    in_valid = 0;
    w = 0;
    while (fin_cnt == f0 && w < 200) begin @(posedge clk); #1 w++; end
    repeat (2) @(posedge clk);
    #1;
    chk("finish_count", fin_cnt - f0, 1);
    chk("accept_count", acc_cnt - a0, plan.size());
    chk("ovf_at_finish", fin_ovf, eovf);
    chk("ovf_sticky", ovf, eovf);
    chk("queues_drained", {fil_q.size(), ifm_q.size()}, 0);
    if (plan.size() == 0) chk("finish_latency", fin_cyc - sc, 1);
  endtask

  initial begin
    #900000 $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 chk("reset_state", {in_ready, fil_v, ifm_v, busy, finish, ovf, fil_sm, ifm_sm, fil_cc, ifm_cc}, 0);
    rst_i = 1;
    @(posedge clk); #1;
    run_layer(40, 16, 4, 2, 3, 3, 0, 0, -1);
    run_layer(40, 16, 4, 2, 3, 3, 50, 0, -1);
    run_layer(40, 16, 4, 0, 3, 3, 0, 0, -1);
    run_layer(16, 16, 4, 2, 3, 3, 30, 0, -1);
    run_layer(40, 16, 4, 2, 3, 3, 20, 1, -1);
    run_layer(40, 16, 4, 2, 3, 3, 0, 0, 14);
    run_layer(16, 16, 4, 2, 3, 3, 0, 0, -1);
    run_layer(32, 32, 2, 1, 8, 3, 10, 0, -1);
    repeat (8)
      run_layer($urandom_range(1, 24), $urandom_range(1, 32), $urandom_range(1, 8), $urandom_range(1, 3),
                $urandom_range(1, 8), $urandom_range(1, 4), $urandom_range(0, 60), 0, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
